// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb
//   Fetch-stage next-PC predictor: a direct-mapped branch target buffer (BTB)
//   paired with a table of 2-bit saturating direction counters (PHT), trained
//   by resolved instructions from EX. Lookup is combinational so fetch gets
//   pc_predict in the same cycle it presents current_pc. Untrained, it
//   behaves as always-not-taken (current_pc + 4).
//
//   Optional feature macro: GSHARE_EN
//     defined   - PHT index = idx XOR zero-extended global history register
//     undefined - bimodal, PHT index = idx, no history register
//
// Ports:
//   clk              system clock, all updates on rising edge
//   reset            asynchronous active-high, clears valid bits/counters/history
//   current_pc       fetch PC being looked up
//   pc_predict       predicted next PC (combinational)
//   predict_taken    1 when pc_predict comes from the BTB
//   update_valid     EX presents a resolved instruction
//   update_is_branch resolved instruction is a branch/jump
//   update_pc        PC of the resolved instruction
//   update_taken     actual direction
//   update_target    actual taken target
module branch_predictor_btb #(
    parameter int         IDX_W    = 5,
    parameter int         HIST_W   = 5,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic [31:0] pc_predict,
    output logic        predict_taken,
    input  logic        update_valid,
    input  logic        update_is_branch,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [31:0]        tgt_mem [ENTRIES];
    logic [1:0]         pht     [ENTRIES];

    logic [HIST_W-1:0]  ghr;
    logic [IDX_W-1:0]   hist_idx;

    logic [IDX_W-1:0]   idx, pidx, upd_idx, upd_pidx;
    logic [TAG_W-1:0]   tag, upd_tag;
    logic               hit, upd_en;
    logic [1:0]         upd_ctr, ctr_next;

    // Instructions are word aligned; the two low PC bits take no part in
    // indexing or tagging.
    logic unused_low_bits;
    assign unused_low_bits = ^{current_pc[1:0], update_pc[1:0]};

    assign idx      = current_pc[IDX_W+1:2];
    assign tag      = current_pc[31:IDX_W+2];
    assign upd_idx  = update_pc[IDX_W+1:2];
    assign upd_tag  = update_pc[31:IDX_W+2];
    assign upd_en   = update_valid && update_is_branch;

    // History is zero in the bimodal build, so one XOR path serves both.
    assign hist_idx = IDX_W'(ghr);
    assign pidx     = idx ^ hist_idx;
    assign upd_pidx = upd_idx ^ hist_idx;

`ifdef GSHARE_EN
    logic [HIST_W-1:0] ghr_next;

    generate
        if (HIST_W == 1) begin : g_ghr1
            assign ghr_next = update_taken;
        end else begin : g_ghrn
            assign ghr_next = {ghr[HIST_W-2:0], update_taken};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ghr <= '0;
        else if (upd_en)
            ghr <= ghr_next;
    end
`else
    assign ghr = '0;
`endif

    // Lookup. valid gates the tag compare so uninitialised tag/target
    // storage never reaches the outputs.
    assign hit           = valid[idx] && (tag_mem[idx] == tag);
    assign predict_taken = hit && pht[pidx][1];
    assign pc_predict    = predict_taken ? tgt_mem[idx] : current_pc + 32'd4;

    // Saturating counter step.
    assign upd_ctr = pht[upd_pidx];

    always_comb begin
        ctr_next = upd_ctr;
        if (update_taken) begin
            if (upd_ctr != 2'b11) ctr_next = upd_ctr + 2'd1;
        end else begin
            if (upd_ctr != 2'b00) ctr_next = upd_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) pht[i] <= CTR_INIT;
        end else if (upd_en) begin
            pht[upd_pidx] <= ctr_next;
            // Not-taken resolutions never allocate nor invalidate.
            if (update_taken) valid[upd_idx] <= 1'b1;
        end
    end

    // Tag/target storage carries no reset; valid qualifies it.
    always_ff @(posedge clk) begin
        if (upd_en && update_taken) begin
            tag_mem[upd_idx] <= upd_tag;
            tgt_mem[upd_idx] <= update_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] current_pc;
    logic [31:0] pc_predict;
    logic        predict_taken;
    logic        update_valid;
    logic        update_is_branch;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;

    branch_predictor_btb dut (
        .clk              (clk),
        .reset            (reset),
        .current_pc       (current_pc),
        .pc_predict       (pc_predict),
        .predict_taken    (predict_taken),
        .update_valid     (update_valid),
        .update_is_branch (update_is_branch),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        uv, ub, ut;
        logic [31:0] upc, utgt;
        logic [31:0] epc;
        logic        etk;
    } vec_t;

    typedef struct {
        logic [31:0] epc;
        logic        etk;
        string       name;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic [31:0] pc, input logic uv, input logic ub,
                                input logic ut, input logic [31:0] upc, input logic [31:0] utgt,
                                input logic [31:0] epc, input logic etk);
        vec_t v;
        v.pc = pc; v.uv = uv; v.ub = ub; v.ut = ut; v.upc = upc; v.utgt = utgt;
        v.epc = epc; v.etk = etk;
        return v;
    endfunction

    task automatic expect_out(input logic [31:0] epc, input logic etk, input string name);
        exp_t e;
        e.epc = epc; e.etk = etk; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sbq.pop_front();
        if (pc_predict !== e.epc || predict_taken !== e.etk) begin
            fails++;
            $display("FAIL %s: got pc_predict=%h predict_taken=%b, want pc_predict=%h predict_taken=%b",
                     e.name, pc_predict, predict_taken, e.epc, e.etk);
        end
    endtask

    // Drive one cycle at negedge, check the pre-update lookup before the
    // rising edge commits the update.
    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        current_pc       = v.pc;
        update_valid     = v.uv;
        update_is_branch = v.ub;
        update_taken     = v.ut;
        update_pc        = v.upc;
        update_target    = v.utgt;
        expect_out(v.epc, v.etk, name);
        #2;
        compare_front();
    endtask

    task automatic idle_check(input logic [31:0] pc, input logic [31:0] epc,
                              input logic etk, input string name);
        step(mk(pc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, epc, etk), name);
    endtask

    initial begin
        reset            = 1'b1;
        current_pc       = 32'h100;
        update_valid     = 1'b0;
        update_is_branch = 1'b0;
        update_taken     = 1'b0;
        update_pc        = 32'h0;
        update_target    = 32'h0;
        #2;
        expect_out(32'h104, 1'b0, "reset_state");
        compare_front();
        @(negedge clk);
        reset = 1'b0;
        idle_check(32'h100, 32'h104, 1'b0, "after_reset");
        idle_check(32'hFFFF_FFFC, 32'h0, 1'b0, "pc_wrap");

`ifndef GSHARE_EN
        //            pc        uv    ub    ut    upc       utgt      epc       etk
        tbl.push_back(mk(32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 1'b0)); // same-cycle: pre-update
        tbl.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h200, 1'b1)); // ctr 10
        tbl.push_back(mk(32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0,   32'h200, 1'b1)); // NT -> 01
        tbl.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h104, 1'b0));
        tbl.push_back(mk(32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 1'b0)); // -> 10
        tbl.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h200, 1'b1)); // BTB kept
        tbl.push_back(mk(32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h200, 1'b1)); // -> 11
        tbl.push_back(mk(32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h200, 1'b1)); // sat 11
        tbl.push_back(mk(32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h200, 1'b1)); // sat 11
        tbl.push_back(mk(32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0,   32'h200, 1'b1)); // -> 10
        tbl.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h200, 1'b1));
        tbl.push_back(mk(32'h180, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h184, 1'b0)); // tag miss
        tbl.push_back(mk(32'h180, 1'b1, 1'b0, 1'b1, 32'h180, 32'h300, 32'h184, 1'b0)); // not a branch
        tbl.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h200, 1'b1));
        tbl.push_back(mk(32'h180, 1'b0, 1'b1, 1'b1, 32'h180, 32'h300, 32'h184, 1'b0)); // not valid
        tbl.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h200, 1'b1));
        tbl.push_back(mk(32'h100, 1'b1, 1'b1, 1'b1, 32'h180, 32'h300, 32'h200, 1'b1)); // alias, ctr 11
        tbl.push_back(mk(32'h180, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h300, 1'b1));
        tbl.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h104, 1'b0)); // overwritten
        tbl.push_back(mk(32'h204, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0,   32'h208, 1'b0)); // 01->00
        tbl.push_back(mk(32'h204, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0,   32'h208, 1'b0)); // sat 00
        tbl.push_back(mk(32'h204, 1'b1, 1'b1, 1'b1, 32'h204, 32'h400, 32'h208, 1'b0)); // -> 01
        tbl.push_back(mk(32'h204, 1'b1, 1'b1, 1'b1, 32'h204, 32'h400, 32'h208, 1'b0)); // -> 10
        tbl.push_back(mk(32'h204, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h400, 1'b1));
        tbl.push_back(mk(32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 1'b0)); // retrain idx0
        tbl.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h200, 1'b1));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        expect_out(32'h104, 1'b0, "async_reset_immediate");
        compare_front();
        current_pc = 32'h204;
        #1;
        expect_out(32'h208, 1'b0, "async_reset_idx1");
        compare_front();
        @(negedge clk);
        reset = 1'b0;
        idle_check(32'h100, 32'h104, 1'b0, "post_reset_100");
        idle_check(32'h204, 32'h208, 1'b0, "post_reset_204");
`else
        // History 00001 via a taken branch at idx 2.
        step(mk(32'h100, 1'b1, 1'b1, 1'b1, 32'h208, 32'h600, 32'h104, 1'b0), "gs_hist1");
        // Train 0x100 under history 00001 -> pht[1]; history becomes 00011.
        step(mk(32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 1'b0), "gs_train");
        idle_check(32'h100, 32'h104, 1'b0, "gs_hist3_pht3");
        // Four not-taken and one taken at idx 16 bring history back to 00001.
        for (int k = 0; k < 4; k++)
            step(mk(32'h100, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h104, 1'b0), $sformatf("gs_nt%0d", k));
        step(mk(32'h100, 1'b1, 1'b1, 1'b1, 32'h40, 32'h500, 32'h104, 1'b0), "gs_t");
        idle_check(32'h100, 32'h200, 1'b1, "gs_hist1_pht1");
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        expect_out(32'h104, 1'b0, "gs_async_reset");
        compare_front();
        @(negedge clk);
        reset = 1'b0;
        idle_check(32'h100, 32'h104, 1'b0, "gs_post_reset");
`endif

        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
